// File: rtl/lstm_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// lstm_pkg: shared widths, saturation limits and FSM encoding. Rev 1.0
// ------------------------------------------------------------------------
package lstm_pkg;

    localparam int DEF_OUTPUT_WIDTH = 16;
    localparam int DEF_ACC_WIDTH    = 24;
    localparam int DEF_TILE_W       = 8;
    localparam int DEF_FIFO_DEPTH   = 4;

    localparam logic signed [DEF_ACC_WIDTH-1:0] SAT_MAX =
        DEF_ACC_WIDTH'((64'sd1 <<< (DEF_OUTPUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [DEF_ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------------
// sync_fifo: single-clock FIFO with registered storage head. Rev 1.0
// ------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int C_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == (C_PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO can still accept a write when a read frees a slot this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_collector.sv
`default_nettype none
// ------------------------------------------------------------------------
// psum_collector: accumulate tile partial sums plus bias, saturate, queue. Rev 1.0
// ------------------------------------------------------------------------
module psum_collector
    import lstm_pkg::*;
#(
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int TILE_W       = DEF_TILE_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [TILE_W-1:0]             cfg_tiles,
    input  logic [OUTPUT_WIDTH-1:0]       bias_in,
    input  logic [OUTPUT_WIDTH-1:0]       psum_in,
    input  logic                          psum_done,
    output logic [OUTPUT_WIDTH-1:0]       out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          sat_flag,
    output logic                          drop_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int C_EXT_W = ACC_WIDTH - OUTPUT_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] C_SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] C_SAT_MIN = ~C_SAT_MAX;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    w_bias_ext;
    logic signed [ACC_WIDTH-1:0]    w_psum_ext;
    logic [TILE_W-1:0]              r_tiles;
    logic [TILE_W-1:0]              r_cnt;
    logic                           r_sat_flag;
    logic                           r_drop_err;
    logic                           w_clamp_hi;
    logic                           w_clamp_lo;
    logic [OUTPUT_WIDTH-1:0]        w_result;
    logic                           w_full;
    logic                           w_empty;
    logic                           w_push;
    logic                           w_last_tile;

    assign w_bias_ext  = {{C_EXT_W{bias_in[OUTPUT_WIDTH-1]}}, bias_in};
    assign w_psum_ext  = {{C_EXT_W{psum_in[OUTPUT_WIDTH-1]}}, psum_in};
    assign w_last_tile = (r_cnt == r_tiles - TILE_W'(1));

    assign w_clamp_hi  = (r_acc > C_SAT_MAX);
    assign w_clamp_lo  = (r_acc < C_SAT_MIN);
    assign w_result    = w_clamp_hi ? C_SAT_MAX[OUTPUT_WIDTH-1:0] :
                         w_clamp_lo ? C_SAT_MIN[OUTPUT_WIDTH-1:0] :
                                      r_acc[OUTPUT_WIDTH-1:0];

    // The SAT state may push into a full FIFO only when the consumer drains it this cycle.
    assign w_push      = (r_state == ST_SAT) && (!w_full || (out_valid && out_ready));

    assign out_valid   = !w_empty;
    assign busy        = (r_state != ST_IDLE);
    assign sat_flag    = r_sat_flag;
    assign drop_err    = r_drop_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (psum_done && w_last_tile) begin
                    w_state_nxt = ST_SAT;
                end
            end
            ST_SAT: begin
                if (w_push) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_tiles    <= '0;
            r_cnt      <= '0;
            r_sat_flag <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc      <= w_bias_ext;
                        r_tiles    <= (cfg_tiles == '0) ? TILE_W'(1) : cfg_tiles;
                        r_cnt      <= '0;
                        r_sat_flag <= 1'b0;
                        r_drop_err <= 1'b0;
                    end else if (psum_done) begin
                        r_drop_err <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (psum_done) begin
                        r_acc <= r_acc + w_psum_ext;
                        r_cnt <= r_cnt + TILE_W'(1);
                    end
                end
                ST_SAT: begin
                    if (psum_done) begin
                        r_drop_err <= 1'b1;
                    end
                    if (w_push && (w_clamp_hi || w_clamp_lo)) begin
                        r_sat_flag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (OUTPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (out_ready),
        .i_data  (w_result),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_psum_collector.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_psum_collector: directed stimulus against a queue-based result model. Rev 1.0
// ------------------------------------------------------------------------
module tb_psum_collector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_tiles = '0;
    logic [15:0] bias_in = '0;
    logic [15:0] psum_in = '0;
    logic        psum_done = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        sat_flag;
    logic        drop_err;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_err    = 0;

    psum_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_tiles  (cfg_tiles),
        .bias_in    (bias_in),
        .psum_in    (psum_in),
        .psum_done  (psum_done),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .sat_flag   (sat_flag),
        .drop_err   (drop_err),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result model: one output = bias + sum of tile psums, clamped to 16 bits,
    // entering the result queue the cycle after its last tile if there is room.
    logic [15:0] q[$];
    bit          m_active, m_pend, m_sat, m_drop, m_res_clamp;
    longint      m_sum;
    int          m_left;
    logic [15:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        bit pop, push, idle;
        if (!rst_n) begin
            q.delete();
            m_active = 0; m_pend = 0; m_sat = 0; m_drop = 0;
        end else begin
            pop  = (q.size() != 0) && out_ready;
            push = m_pend && ((q.size() < DEPTH) || pop);
            idle = !m_active && !m_pend;
            if (pop) q.delete(0);
            if (push) begin
                q.push_back(m_res);
                m_pend = 0;
                if (m_res_clamp) m_sat = 1;
            end
            if (idle) begin
                if (start) begin
                    m_active = 1;
                    m_sum    = longint'($signed(bias_in));
                    m_left   = (cfg_tiles == 0) ? 1 : int'(cfg_tiles);
                    m_sat    = 0;
                    m_drop   = 0;
                end else if (psum_done) begin
                    m_drop = 1;
                end
            end else if (m_active) begin
                if (psum_done) begin
                    m_sum  += longint'($signed(psum_in));
                    m_left -= 1;
                    if (m_left == 0) begin
                        m_active = 0;
                        m_pend   = 1;
                        if (m_sum > 32767) begin
                            m_res = 16'h7FFF; m_res_clamp = 1;
                        end else if (m_sum < -32768) begin
                            m_res = 16'h8000; m_res_clamp = 1;
                        end else begin
                            m_res = m_sum[15:0]; m_res_clamp = 0;
                        end
                    end
                end
            end else if (psum_done) begin
                m_drop = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", out_valid, q.size() != 0);
            chk("m_count", fifo_count, q.size());
            chk("m_busy", busy, m_active || m_pend);
            chk("m_sat", sat_flag, m_sat);
            chk("m_drop", drop_err, m_drop);
            if (q.size() != 0) chk("m_data", out_data, q[0]);
        end else begin
            chk("rst_valid", out_valid, 0);
            chk("rst_count", fifo_count, 0);
            chk("rst_busy", busy, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] tiles, input logic [15:0] bias);
        start = 1'b1; cfg_tiles = tiles; bias_in = bias;
        tick();
        start = 1'b0;
    endtask

    task automatic do_psum(input logic [15:0] p);
        psum_in = p; psum_done = 1'b1;
        tick();
        psum_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data", out_data, 16'h0000);
        chk("reset_valid", out_valid, 0);
        chk("reset_sat", sat_flag, 0);
        chk("reset_drop", drop_err, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single tile, two-cycle latency from the done pulse
        do_start(8'd1, 16'h0010);
        do_psum(16'h0100);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 16'h0110);
        chk("single_sat", sat_flag, 0);
        tick();

        // Three tiles
        do_start(8'd3, 16'h0000);
        do_psum(16'h1000);
        do_psum(16'h2000);
        do_psum(16'h3000);
        chk("multi_busy_sat", busy, 1);
        tick();
        chk("multi_data", out_data, 16'h6000);
        chk("multi_busy", busy, 0);
        tick();

        // Positive and negative saturation
        do_start(8'd2, 16'h0000);
        do_psum(16'h7000);
        do_psum(16'h7000);
        tick();
        chk("satp_data", out_data, 16'h7FFF);
        chk("satp_flag", sat_flag, 1);
        tick();
        do_start(8'd2, 16'h0000);
        chk("sat_clear", sat_flag, 0);
        do_psum(16'h9000);
        do_psum(16'h9000);
        tick();
        chk("satn_data", out_data, 16'h8000);
        chk("satn_flag", sat_flag, 1);
        tick();

        // cfg_tiles of zero acts as one tile
        do_start(8'd0, 16'h0005);
        do_psum(16'h0007);
        tick();
        chk("zero_tiles_data", out_data, 16'h000C);
        tick();

        // Dropped pulse in IDLE, clear on start, start ignored mid-output
        do_psum(16'h1234);
        chk("drop_idle", drop_err, 1);
        chk("drop_no_push", fifo_count, 0);
        do_start(8'd2, 16'h0000);
        chk("drop_clear", drop_err, 0);
        do_psum(16'h0001);
        do_start(8'd1, 16'h0100);
        do_psum(16'h0002);
        tick();
        chk("restart_ignored", out_data, 16'h0003);
        tick();

        // Backpressure: four queued, fifth stalls in SAT
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            do_start(8'd1, 16'(i));
            do_psum(16'h0010);
            tick();
        end
        chk("bp_full", fifo_count, 4);
        do_start(8'd1, 16'h0005);
        do_psum(16'h0010);
        tick();
        tick();
        chk("bp_stall_busy", busy, 1);
        chk("bp_stall_count", fifo_count, 4);
        do_psum(16'h0055);
        chk("bp_stall_drop", drop_err, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_swap_count", fifo_count, 4);
        chk("bp_swap_head", out_data, 16'h0012);
        chk("bp_swap_busy", busy, 0);
        for (int i = 0; i < 10 && fifo_count != 0; i++) tick();
        chk("bp_drained", fifo_count, 0);

        // Reset mid-accumulation with two queued results
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            do_start(8'd1, 16'h0020);
            do_psum(16'(i));
            tick();
        end
        do_start(8'd3, 16'h0000);
        do_psum(16'h0100);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_count", fifo_count, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", out_data, 16'h0000);
        chk("midrst_drop", drop_err, 0);
        chk("midrst_sat", sat_flag, 0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        do_start(8'd1, 16'hFFFF);
        do_psum(16'h0003);
        tick();
        chk("post_rst_data", out_data, 16'h0002);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
